// File: rtl/vga_console_writer.sv
// Text-mode console writer: turns a stream of character codes into VRAM cell writes,
// tracking a cursor and blanking rows or the whole screen as the cursor moves.
module vga_console_writer #(
    parameter int         COLS  = 40,
    parameter int         ROWS  = 30,
    parameter logic [7:0] BLANK = 8'h20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [10:0] vram_waddr,
    output logic [7:0]  vram_wdata,
    output logic        vram_we,
    output logic [5:0]  cursor_col,
    output logic [4:0]  cursor_row,
    output logic        busy
);

    localparam logic [10:0] CELLS    = 11'(COLS * ROWS);
    localparam logic [10:0] COLS_W   = 11'(COLS);
    localparam logic [5:0]  LAST_COL = 6'(COLS - 1);
    localparam logic [4:0]  LAST_ROW = 5'(ROWS - 1);

    typedef enum logic [1:0] {
        CLR_SCREEN,
        CLR_ROW,
        IDLE
    } state_t;

    state_t      state, state_n;
    logic [5:0]  col, col_n;
    logic [4:0]  row, row_n;
    logic [10:0] clr_addr, clr_addr_n;
    logic [10:0] clr_end, clr_end_n;
    logic        we_n;
    logic [10:0] waddr_n;
    logic [7:0]  wdata_n;
    logic [10:0] row_base;
    logic [10:0] next_base;
    logic [10:0] cell_addr;
    logic [4:0]  next_row;

    // Start address of the cursor row; the default width uses shift-add, other widths track it incrementally.
    generate
        if (COLS == 40) begin : g_shift
            assign row_base = (11'(row) << 5) + (11'(row) << 3);
        end else begin : g_base
            logic [10:0] base_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    base_q <= '0;
                else if (row_n == '0)
                    base_q <= '0;
                else if (row_n != row)
                    base_q <= base_q + COLS_W;
            end
            assign row_base = base_q;
        end
    endgenerate

    assign next_row  = (row == LAST_ROW) ? '0 : row + 5'd1;
    assign next_base = (row == LAST_ROW) ? '0 : row_base + COLS_W;
    assign cell_addr = row_base + 11'(col);

    always_comb begin
        state_n    = state;
        col_n      = col;
        row_n      = row;
        clr_addr_n = clr_addr;
        clr_end_n  = clr_end;
        we_n       = 1'b0;
        waddr_n    = vram_waddr;
        wdata_n    = vram_wdata;

        case (state)
            CLR_SCREEN, CLR_ROW: begin
                // clr_end is exclusive; one idle cycle follows the last blank before accepting input.
                if (clr_addr != clr_end) begin
                    we_n       = 1'b1;
                    waddr_n    = clr_addr;
                    wdata_n    = BLANK;
                    clr_addr_n = clr_addr + 11'd1;
                end else begin
                    state_n = IDLE;
                end
            end
            IDLE: begin
                if (in_valid) begin
                    if (in_data >= 8'h20) begin
                        we_n    = 1'b1;
                        waddr_n = cell_addr;
                        wdata_n = in_data;
                        if (col == LAST_COL) begin
                            col_n      = '0;
                            row_n      = next_row;
                            clr_addr_n = next_base;
                            clr_end_n  = next_base + COLS_W;
                            state_n    = CLR_ROW;
                        end else begin
                            col_n = col + 6'd1;
                        end
                    end else begin
                        case (in_data)
                            8'h0A: begin
                                col_n      = '0;
                                row_n      = next_row;
                                clr_addr_n = next_base;
                                clr_end_n  = next_base + COLS_W;
                                state_n    = CLR_ROW;
                            end
                            8'h0D: col_n = '0;
                            8'h08: begin
                                if (col != '0) begin
                                    col_n   = col - 6'd1;
                                    we_n    = 1'b1;
                                    waddr_n = cell_addr - 11'd1;
                                    wdata_n = BLANK;
                                end
                            end
                            8'h0C: begin
                                col_n      = '0;
                                row_n      = '0;
                                clr_addr_n = '0;
                                clr_end_n  = CELLS;
                                state_n    = CLR_SCREEN;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            default: begin
                state_n    = CLR_SCREEN;
                clr_addr_n = '0;
                clr_end_n  = CELLS;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= CLR_SCREEN;
            col        <= '0;
            row        <= '0;
            clr_addr   <= '0;
            clr_end    <= CELLS;
            vram_we    <= 1'b0;
            vram_waddr <= '0;
            vram_wdata <= '0;
        end else begin
            state      <= state_n;
            col        <= col_n;
            row        <= row_n;
            clr_addr   <= clr_addr_n;
            clr_end    <= clr_end_n;
            vram_we    <= we_n;
            vram_waddr <= waddr_n;
            vram_wdata <= wdata_n;
        end
    end

    assign in_ready   = (state == IDLE);
    assign busy       = ~in_ready;
    assign cursor_col = col;
    assign cursor_row = row;

endmodule

// File: tb/tb_vga_console_writer.sv
// Scoreboard bench for vga_console_writer: a cursor model predicts every VRAM write
// and the cursor/ready state seen alongside it.
module tb_vga_console_writer;

    localparam int COLS  = 40;
    localparam int ROWS  = 30;
    localparam int BLANK = 'h20;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [10:0] vram_waddr;
    logic [7:0]  vram_wdata;
    logic        vram_we;
    logic [5:0]  cursor_col;
    logic [4:0]  cursor_row;
    logic        busy;

    vga_console_writer #(.COLS(COLS), .ROWS(ROWS), .BLANK(8'h20)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .vram_waddr (vram_waddr),
        .vram_wdata (vram_wdata),
        .vram_we    (vram_we),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int addr;
        int data;
        int ready;
        int col;
        int row;
    } expT;

    expT expQ[$];
    expT monE;
    int  vectorCount = 0;
    int  missCount   = 0;
    int  popCount    = 0;
    int  mCol        = 0;
    int  mRow        = 0;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        vectorCount++;
        if (observed != expected) begin
            missCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic pushWrite(input int addr, input int data, input int ready);
        expT e;
        e.addr  = addr;
        e.data  = data;
        e.ready = ready;
        e.col   = mCol;
        e.row   = mRow;
        expQ.push_back(e);
    endtask

    task automatic pushRowClear();
        for (int i = 0; i < COLS; i++)
            pushWrite(mRow * COLS + i, BLANK, 0);
    endtask

    task automatic pushScreenClear();
        for (int i = 0; i < COLS * ROWS; i++)
            pushWrite(i, BLANK, 0);
    endtask

    // Cursor model: applied at the moment a code is known to be accepted.
    task automatic modelAccept(input logic [7:0] code);
        int addr;
        if (code >= 8'h20) begin
            addr = mRow * COLS + mCol;
            if (mCol == COLS - 1) begin
                mCol = 0;
                mRow = (mRow + 1) % ROWS;
                pushWrite(addr, int'(code), 0);
                pushRowClear();
            end else begin
                mCol++;
                pushWrite(addr, int'(code), 1);
            end
        end else begin
            case (code)
                8'h0A: begin
                    mCol = 0;
                    mRow = (mRow + 1) % ROWS;
                    pushRowClear();
                end
                8'h0D: mCol = 0;
                8'h08: begin
                    if (mCol > 0) begin
                        mCol--;
                        pushWrite(mRow * COLS + mCol, BLANK, 1);
                    end
                end
                8'h0C: begin
                    mCol = 0;
                    mRow = 0;
                    pushScreenClear();
                end
                default: ;
            endcase
        end
    endtask

    // Offers one code, waits (bounded) for acceptance, returns #1 after the accepting edge.
    task automatic applyStimulus(input logic [7:0] code);
        int budget;
        in_data  = code;
        in_valid = 1'b1;
        budget   = 3000;
        while (!in_ready && budget > 0) begin
            @(posedge clk);
            #1;
            budget--;
        end
        if (!in_ready) begin
            checkOutput("ready_timeout", int'(in_ready), 1);
            in_valid = 1'b0;
            return;
        end
        modelAccept(code);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic waitDrain(input string tag);
        int budget;
        budget = 5000;
        while ((expQ.size() != 0 || !in_ready) && budget > 0) begin
            @(posedge clk);
            #1;
            budget--;
        end
        if (budget == 0)
            checkOutput({tag, "_timeout"}, expQ.size(), 0);
        checkOutput({tag, "_col"}, int'(cursor_col), mCol);
        checkOutput({tag, "_row"}, int'(cursor_row), mRow);
        checkOutput({tag, "_ready"}, int'(in_ready), 1);
    endtask

    task automatic doReset(input string tag);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        expQ.delete();
        mCol = 0;
        mRow = 0;
        #1;
        checkOutput({tag, "_we"}, int'(vram_we), 0);
        checkOutput({tag, "_waddr"}, int'(vram_waddr), 0);
        checkOutput({tag, "_wdata"}, int'(vram_wdata), 0);
        checkOutput({tag, "_col"}, int'(cursor_col), 0);
        checkOutput({tag, "_row"}, int'(cursor_row), 0);
        checkOutput({tag, "_ready"}, int'(in_ready), 0);
        checkOutput({tag, "_busy"}, int'(busy), 1);
        repeat (3) @(posedge clk);
        #1;
        pushScreenClear();
        rst_n = 1'b1;
    endtask

    // Every write strobe must match the head of the scoreboard, including the cursor and handshake state.
    always @(negedge clk) begin
        if (rst_n && vram_we) begin
            if (expQ.size() == 0) begin
                checkOutput("spurious_we", int'(vram_we), 0);
            end else begin
                monE = expQ.pop_front();
                popCount++;
                checkOutput("waddr", int'(vram_waddr), monE.addr);
                checkOutput("wdata", int'(vram_wdata), monE.data);
                checkOutput("ready_at_write", int'(in_ready), monE.ready);
                checkOutput("busy_at_write", int'(busy), 1 - monE.ready);
                checkOutput("col_at_write", int'(cursor_col), monE.col);
                checkOutput("row_at_write", int'(cursor_row), monE.row);
            end
        end
    end

    initial begin
        int target;
        int budget;
        int pick;

        doReset("por");
        waitDrain("por_clear");

        applyStimulus(8'h41);
        applyStimulus(8'h42);
        waitDrain("ab");

        applyStimulus(8'h0D);
        repeat (29) applyStimulus(8'h0A);
        waitDrain("row29");
        repeat (40) applyStimulus(8'h41);
        waitDrain("wrap");

        repeat (3) applyStimulus(8'h0A);
        repeat (5) applyStimulus(8'h78);
        waitDrain("pos3_5");
        applyStimulus(8'h08);
        waitDrain("bs");
        applyStimulus(8'h0D);
        waitDrain("cr");
        applyStimulus(8'h08);
        waitDrain("bs_col0");
        applyStimulus(8'h07);
        waitDrain("bel");

        repeat (7) applyStimulus(8'h0A);
        repeat (17) applyStimulus(8'h79);
        waitDrain("pos10_17");
        applyStimulus(8'h0C);
        applyStimulus(8'h5A);
        waitDrain("ff");

        for (int i = 0; i < 40; i++) begin
            pick = $urandom_range(0, 9);
            case (pick)
                0:       applyStimulus(8'h0A);
                1:       applyStimulus(8'h0D);
                2:       applyStimulus(8'h08);
                3:       applyStimulus(8'h07);
                default: applyStimulus(8'($urandom_range(32, 255)));
            endcase
        end
        waitDrain("rand");

        applyStimulus(8'h0C);
        target = popCount + 600;
        budget = 2000;
        while (popCount < target && budget > 0) begin
            @(posedge clk);
            #1;
            budget--;
        end
        checkOutput("abort_reached", popCount, target);
        checkOutput("abort_we_before", int'(vram_we), 1);
        doReset("abort");
        waitDrain("reclear");

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule

// File: doc/vga_console_writer.md
VGA_CONSOLE_WRITER -- requirements
Module: vga_console_writer

Interface
REQ-001 SHALL have parameter COLS, default 40, text columns per row.
REQ-002 SHALL have parameter ROWS, default 30, text rows per screen.
REQ-003 SHALL have parameter BLANK, default 8'h20, fill code written when clearing.
REQ-004 SHALL have port clk  input  1  sole clock; it drives all logic and also feeds the display vram_clk.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port in_data  input  8  character code.
REQ-007 SHALL have port in_valid  input  1  in_data offered.
REQ-008 SHALL have port in_ready  output  1  writer can accept; a transfer occurs when in_valid and in_ready are both high on a clk rising edge.
REQ-009 SHALL have port vram_waddr  output  11  cell address, row*COLS+col.
REQ-010 SHALL have port vram_wdata  output  8  cell code.
REQ-011 SHALL have port vram_we  output  1  write strobe, one cell per cycle.
REQ-012 SHALL have port cursor_col  output  6  current column, 0..COLS-1.
REQ-013 SHALL have port cursor_row  output  5  current row, 0..ROWS-1.
REQ-014 SHALL have port busy  output  1  clear in progress; equals !in_ready.

Function
REQ-015 SHALL implement FSM states CLR_SCREEN, CLR_ROW, IDLE; CLR_SCREEN is entered on reset release.
REQ-016 SHALL drive in_ready=1 only in IDLE, so back-to-back transfers are accepted one per cycle.
REQ-017 SHALL register all vram_* outputs: a transfer accepted at edge N produces its vram_we pulse in the cycle following edge N.
REQ-018 SHALL drive vram_we=0 in IDLE on any cycle with no qualifying transfer on the previous edge.
REQ-019 SHALL treat a printable code (0x20..0xFF) as: write the code at (row,col), then col+1.
REQ-020 SHALL, when a printable code is written at col=COLS-1, set col=0, advance the row, and enter CLR_ROW.
REQ-021 SHALL treat 0x0A (LF) as: col=0, advance the row, enter CLR_ROW; no character write.
REQ-022 SHALL treat 0x0D (CR) as: col=0; row unchanged; no write.
REQ-023 SHALL treat 0x08 (BS) as: if col>0, col-1 and write BLANK at the new position; if col=0, no effect.
REQ-024 SHALL treat 0x0C (FF) as: enter CLR_SCREEN and set the cursor to (0,0).
REQ-025 SHALL accept and discard all other codes 0x00..0x1F with no state change.
REQ-026 SHALL define "advance the row" as row+1, wrapping from ROWS-1 to 0; the block does not scroll.
REQ-027 SHALL, in CLR_ROW, write BLANK to the COLS cells of the new row at ascending addresses on consecutive cycles, then return to IDLE.
REQ-028 SHALL, in CLR_SCREEN, write BLANK to addresses 0..COLS*ROWS-1 on consecutive cycles (1200 writes at the defaults), then return to IDLE with the cursor at (0,0).
REQ-029 SHALL compute addresses with no multiplier: row*40 = (row<<5)+(row<<3) at the defaults; generic parameters use an incrementing base register.
REQ-030 SHALL keep cursor_col/cursor_row at their post-command values for the whole of any clear sequence.
REQ-031 SHALL ignore in_valid while busy; the upstream holds in_data stable until the transfer.

Reset
REQ-032 SHALL, while rst_n=0, drive vram_we=0, vram_waddr=0, vram_wdata=0, cursor=(0,0), in_ready=0, busy=1.
REQ-033 SHALL begin CLR_SCREEN on the first clk edge after rst_n rises, with the first write at address 0.
REQ-034 SHALL treat an rst_n assertion mid-clear or mid-transfer as an abort; no partial state is retained, and the sequence restarts per REQ-033.

Verification
REQ-035 Release reset -> 1200 consecutive vram_we pulses, addresses 0..1199, data 0x20; in_ready rises on the next cycle, cursor=(0,0).
REQ-036 Send "AB" back-to-back from (0,0) -> writes (0,0x41),(1,0x42) on consecutive cycles; cursor=(0,2); in_ready held high.
REQ-037 Send 40 x 0x41 on row 29 -> last write at addr 1199; cursor=(0,0); then 40 blanks at addresses 0..39 with in_ready=0 throughout.
REQ-038 At cursor (3,5): send 0x08 -> blank at addr 124, cursor=(3,4); at col 0, 0x08 -> no write; 0x0D -> col 0; 0x07 -> no change.
REQ-039 Send 0x0C at cursor (10,17) -> cursor=(0,0); 1200 blank writes follow; in_valid held high during the clear is not accepted.
REQ-040 Pull rst_n low at write 600 of a clear -> vram_we=0 immediately (asynchronous); after release a full 0..1199 clear restarts.
